controle_exibicao_sequencia: RTL and testbench

- Sequencer for the memory game's "show sequence" phase.
- Walks the sequence memory from address 0 to the current round limit and latches each stored colour.
- Drives the player LEDs with that colour for a programmable ON time, then a blank OFF gap, per element.
- Sits between the game control FSM (start/abort/done handshake) and the datapath (memory address, LED outputs).

---
 rtl/controle_exibicao_sequencia_pkg.sv | 34 +++
 rtl/controle_exibicao_sequencia_temporizador.sv | 57 +++++
 rtl/controle_exibicao_sequencia.sv | 159 +++++++++++++++
 tb/tb_controle_exibicao_sequencia.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/controle_exibicao_sequencia_pkg.sv
// ----------------------------------------------------------------------------
// controle_exibicao_sequencia_pkg
// Shared definitions for the "show sequence" sequencer of the memory game:
//   - state codes (OCIOSO..FIM), also used as the hexa7seg debug code
//   - debug-code encoder for the db_estado output
//   - timer width helper used by temporizador_exibicao
// ----------------------------------------------------------------------------
package controle_exibicao_sequencia_pkg;

    localparam int ESTADO_W = 3;

    localparam logic [ESTADO_W-1:0] OCIOSO  = 3'd0;
    localparam logic [ESTADO_W-1:0] CARREGA = 3'd1;
    localparam logic [ESTADO_W-1:0] ACENDE  = 3'd2;
    localparam logic [ESTADO_W-1:0] APAGA   = 3'd3;
    localparam logic [ESTADO_W-1:0] FIM     = 3'd4;

    localparam int DB_W = 4;

    // The debug display shows the raw state code, zero-extended to a nibble.
    function automatic logic [DB_W-1:0] codigo_debug(input logic [ESTADO_W-1:0] estado);
        return {1'b0, estado};
    endfunction

    // Enough bits to count 0..max(T_ON,T_OFF)-1, never less than one bit.
    function automatic int largura_timer(input int t_on, input int t_off);
        int maior;
        int largura;
        maior   = (t_on > t_off) ? t_on : t_off;
        largura = $clog2(maior);
        return (largura < 1) ? 1 : largura;
    endfunction

endpackage

// File: rtl/controle_exibicao_sequencia_temporizador.sv
// ----------------------------------------------------------------------------
// temporizador_exibicao
// Modulo counter timing the ON and OFF phases of each shown element.
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-high
//   limpa      - forces the count to zero (highest priority after reset)
//   conta      - advances the count by one per cycle
//   sel_apaga  - terminal select: 0 = T_ON-1, 1 = T_OFF-1
//   fim_tempo  - high while the count equals the selected terminal value
// The count wraps to zero on its own when counting at terminal, so the
// ON->OFF hand-over needs no separate clear cycle.
// ----------------------------------------------------------------------------
module temporizador_exibicao
    import controle_exibicao_sequencia_pkg::*;
#(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    input  logic sel_apaga,
    output logic fim_tempo
);

    if (T_ON < 1 || T_OFF < 1) begin : g_parametro_invalido
        $fatal(1, "temporizador_exibicao: T_ON and T_OFF must both be at least 1");
    end

    localparam int TW = largura_timer(T_ON, T_OFF);
    localparam logic [TW-1:0] TERMINAL_ON  = TW'(T_ON - 1);
    localparam logic [TW-1:0] TERMINAL_OFF = TW'(T_OFF - 1);

    logic [TW-1:0] contagem;

    assign fim_tempo = (contagem == (sel_apaga ? TERMINAL_OFF : TERMINAL_ON));

    // Count register: clear, wrap at terminal, or advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (conta) begin
            if (fim_tempo) begin
                contagem <= '0;
            end else begin
                contagem <= contagem + TW'(1);
            end
        end else begin
            contagem <= contagem;
        end
    end

endmodule

// File: rtl/controle_exibicao_sequencia.sv
// ----------------------------------------------------------------------------
// controle_exibicao_sequencia
// Plays back the stored colour sequence, addresses 0..limite, on the LEDs:
// each element is loaded (1 cycle), lit for T_ON cycles, blanked for T_OFF.
// Ports:
//   clock, reset     - system clock, synchronous active-high reset
//   iniciar          - start request (only honoured while idle)
//   cancela          - abort back to idle, no completion pulse
//   limite           - index of the last element to show (captured at start)
//   dado_memoria     - memory read data for endereco (ready by end of cycle)
//   endereco         - memory read address
//   leds             - colour shown to the player
//   ocupado          - high whenever not idle
//   fim_sequencia    - one-cycle pulse after the last element's gap
//   db_estado        - state code for the debug display
// All outputs are registers loaded from the next-state decode, so they
// change together with the state and have no combinational input path.
// ----------------------------------------------------------------------------
module controle_exibicao_sequencia
    import controle_exibicao_sequencia_pkg::*;
#(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250,
    parameter int AW    = 4,
    parameter int DW    = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            iniciar,
    input  logic            cancela,
    input  logic [AW-1:0]   limite,
    input  logic [DW-1:0]   dado_memoria,
    output logic [AW-1:0]   endereco,
    output logic [DW-1:0]   leds,
    output logic            ocupado,
    output logic            fim_sequencia,
    output logic [DB_W-1:0] db_estado
);

    logic [ESTADO_W-1:0] estado;
    logic [ESTADO_W-1:0] proximo;
    logic [AW-1:0]       limite_reg;
    logic [DW-1:0]       cor;

    logic                fim_tempo;
    logic                conta_tempo;

    logic [AW-1:0]       endereco_prox;
    logic [DW-1:0]       cor_prox;
    logic [DW-1:0]       leds_prox;
    logic [AW-1:0]       limite_prox;

    assign conta_tempo = (estado == ACENDE) || (estado == APAGA);

    temporizador_exibicao #(
        .T_ON  (T_ON),
        .T_OFF (T_OFF)
    ) u_temporizador (
        .clock     (clock),
        .reset     (reset),
        .limpa     (!conta_tempo),
        .conta     (conta_tempo),
        .sel_apaga (estado == APAGA),
        .fim_tempo (fim_tempo)
    );

    // Next-state decode; an abort outside idle overrides every transition.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar && !cancela) begin
                    proximo = CARREGA;
                end else begin
                    proximo = OCIOSO;
                end
            end
            CARREGA: proximo = ACENDE;
            ACENDE: begin
                if (fim_tempo) begin
                    proximo = APAGA;
                end else begin
                    proximo = ACENDE;
                end
            end
            APAGA: begin
                if (!fim_tempo) begin
                    proximo = APAGA;
                end else if (endereco == limite_reg) begin
                    proximo = FIM;
                end else begin
                    proximo = CARREGA;
                end
            end
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
        if (cancela && (estado != OCIOSO)) begin
            proximo = OCIOSO;
        end else begin
            proximo = proximo;
        end
    end

    // Datapath next values: limit capture, address step, colour latch, LEDs.
    always_comb begin
        limite_prox   = limite_reg;
        endereco_prox = endereco;
        cor_prox      = cor;
        leds_prox     = '0;
        if ((estado == OCIOSO) && (proximo == CARREGA)) begin
            limite_prox = limite;
        end else begin
            limite_prox = limite_reg;
        end
        // Terminal check is done before this increment, so no wrap occurs.
        if (proximo == OCIOSO) begin
            endereco_prox = '0;
        end else if ((estado == APAGA) && (proximo == CARREGA)) begin
            endereco_prox = endereco + AW'(1);
        end else begin
            endereco_prox = endereco;
        end
        if ((estado == CARREGA) && (proximo == ACENDE)) begin
            cor_prox = dado_memoria;
        end else begin
            cor_prox = cor;
        end
        if (proximo == ACENDE) begin
            leds_prox = cor_prox;
        end else begin
            leds_prox = '0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= OCIOSO;
            limite_reg    <= '0;
            endereco      <= '0;
            cor           <= '0;
            leds          <= '0;
            ocupado       <= 1'b0;
            fim_sequencia <= 1'b0;
            db_estado     <= '0;
        end else begin
            estado        <= proximo;
            limite_reg    <= limite_prox;
            endereco      <= endereco_prox;
            cor           <= cor_prox;
            leds          <= leds_prox;
            ocupado       <= (proximo != OCIOSO);
            fim_sequencia <= (proximo == FIM);
            db_estado     <= codigo_debug(proximo);
        end
    end

endmodule

// File: tb/tb_controle_exibicao_sequencia.sv
// ----------------------------------------------------------------------------
// tb_controle_exibicao_sequencia
// Scoreboard bench: stimulus tasks push the expected per-cycle output
// snapshot into a queue; a monitor pops one entry after every rising edge
// and compares it with the DUT outputs. Configuration: T_ON=4, T_OFF=2,
// memory holds 0001,0010,0100,1000 repeating.
// ----------------------------------------------------------------------------
module tb_controle_exibicao_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int PER   = 1 + T_ON + T_OFF;

    typedef struct packed {
        logic [DW-1:0] leds;
        logic [AW-1:0] ender;
        logic          ocupado;
        logic          fim;
        logic [3:0]    db;
    } amostra_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic          cancela;
    logic [AW-1:0] limite;
    logic [DW-1:0] dado_memoria;
    logic [AW-1:0] endereco;
    logic [DW-1:0] leds;
    logic          ocupado;
    logic          fim_sequencia;
    logic [3:0]    db_estado;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] cores_esperadas [4];

    amostra_t fila [$];
    int       erros  = 0;
    int       checks = 0;
    int       ciclo  = 0;

    controle_exibicao_sequencia #(
        .T_ON (T_ON),
        .T_OFF(T_OFF),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .cancela      (cancela),
        .limite       (limite),
        .dado_memoria (dado_memoria),
        .endereco     (endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .fim_sequencia(fim_sequencia),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Memory read registered on the falling edge: data for a new address is
    // stable well before the next rising edge samples it.
    always @(negedge clock) dado_memoria <= mem[endereco];

    // Monitor: one expected snapshot per rising edge while the queue is busy.
    always @(posedge clock) begin
        amostra_t esp;
        amostra_t obs;
        #1;
        ciclo++;
        if (fila.size() > 0) begin
            esp = fila.pop_front();
            obs = '{leds: leds, ender: endereco, ocupado: ocupado,
                    fim: fim_sequencia, db: db_estado};
            checks++;
            if (obs !== esp) begin
                erros++;
                $display("FAIL trace cycle %0d: got leds=%b end=%0d ocup=%b fim=%b db=%0d, expected leds=%b end=%0d ocup=%b fim=%b db=%0d",
                         ciclo, obs.leds, obs.ender, obs.ocupado, obs.fim, obs.db,
                         esp.leds, esp.ender, esp.ocupado, esp.fim, esp.db);
            end
        end
    end

    function automatic amostra_t ocioso();
        return '{leds: 4'b0000, ender: 4'd0, ocupado: 1'b0, fim: 1'b0, db: 4'd0};
    endfunction

    // Expected snapshots for a full run from the start edge to idle again.
    task automatic empilha_execucao(input int lim);
        amostra_t a;
        int n;
        n = (lim + 1) * PER;
        for (int k = 0; k < n; k++) begin
            int j;
            int p;
            j = k / PER;
            p = k % PER;
            a.ender   = AW'(j);
            a.ocupado = 1'b1;
            a.fim     = 1'b0;
            if (p == 0) begin
                a.leds = 4'b0000; a.db = 4'd1;
            end else if (p <= T_ON) begin
                a.leds = cores_esperadas[j % 4]; a.db = 4'd2;
            end else begin
                a.leds = 4'b0000; a.db = 4'd3;
            end
            fila.push_back(a);
        end
        fila.push_back('{leds: 4'b0000, ender: AW'(lim), ocupado: 1'b1, fim: 1'b1, db: 4'd4});
        fila.push_back(ocioso());
    endtask

    task automatic inicia(input int lim);
        limite  = AW'(lim);
        iniciar = 1'b1;
        empilha_execucao(lim);
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic espera_fila(input int orcamento);
        int n;
        n = 0;
        while (fila.size() != 0 && n < orcamento) begin
            @(negedge clock);
            n++;
        end
        if (fila.size() != 0) begin
            checks++;
            erros++;
            $display("FAIL timeout: %0d expected snapshots left, required 0", fila.size());
            fila.delete();
        end
    endtask

    initial begin
        cores_esperadas[0] = 4'b0001;
        cores_esperadas[1] = 4'b0010;
        cores_esperadas[2] = 4'b0100;
        cores_esperadas[3] = 4'b1000;
        for (int i = 0; i < 16; i++) mem[i] = cores_esperadas[i % 4];

        reset   = 1'b1;
        iniciar = 1'b0;
        cancela = 1'b0;
        limite  = '0;
        repeat (2) @(negedge clock);
        fila.push_back(ocioso());
        @(negedge clock);
        reset = 1'b0;
        fila.push_back(ocioso());
        @(negedge clock);

        // Three elements, completion pulse (limite+1)*PER edges after start.
        inicia(2);
        espera_fila(100);

        // Single element.
        inicia(0);
        espera_fila(50);

        // Full 16-entry memory, address stops at 15.
        inicia(15);
        espera_fila(200);

        // Abort during the second element's ON phase, then restart.
        inicia(2);
        repeat (8) @(negedge clock);
        cancela = 1'b1;
        fila.delete();
        fila.push_back(ocioso());
        fila.push_back(ocioso());
        @(negedge clock);
        cancela = 1'b0;
        espera_fila(10);
        inicia(1);
        espera_fila(50);

        // Restart request and limit change while busy are ignored.
        inicia(2);
        repeat (3) @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'd5;
        @(negedge clock);
        iniciar = 1'b0;
        espera_fila(100);

        // Start and abort together while idle: stays idle.
        iniciar = 1'b1;
        cancela = 1'b1;
        fila.push_back(ocioso());
        @(negedge clock);
        iniciar = 1'b0;
        cancela = 1'b0;
        espera_fila(10);

        // Reset during the OFF gap.
        inicia(1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        fila.delete();
        fila.push_back(ocioso());
        @(negedge clock);
        reset = 1'b0;
        fila.push_back(ocioso());
        espera_fila(10);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
